serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes A − B one bit per clock, LSB first, with a single full-subtractor cell and a registered borrow.
- For negative results, a second serial pass forms the magnitude so the FND/BCD display path receives the absolute value plus a sign flag.
- Sits between the switch-input capture logic and the BCD-to-FND decoder. It is the subtraction counterpart to the team's ripple adder datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- i_clk  input  1  system clock, rising-edge active
- i_reset_n  input  1  asynchronous active-low reset
- i_start  input  1  request pulse; sampled only in IDLE
- i_a  input  WIDTH  minuend, captured on the edge that accepts i_start
- i_b  input  WIDTH  subtrahend, captured with i_a
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  single-cycle pulse; results are valid from this cycle onward
- o_diff  output  WIDTH  (A − B) mod 2^WIDTH
- o_borrow  output  1  final borrow-out; 1 when A < B
- o_neg  output  1  sign of the result; equals o_borrow
- o_mag  output  WIDTH  |A − B|

Behaviour:
- Reset (i_reset_n=0, asynchronous, from any state):
  - State goes to IDLE.
  - o_busy, o_done, o_diff, o_borrow, o_neg, o_mag all 0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - An operation in progress is abandoned; no o_done follows.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - i_start=1 at edge E0 captures i_a/i_b into shift registers, clears the borrow flop and bit counter, and moves to SUB.
  - i_start=0 stays in IDLE.
- SUB (edges E1..E_WIDTH):
  - Per edge, with a0/b0 as the current LSBs and br as the borrow flop:
    - d = a0^b0^br
    - br_next = (~a0&b0) | (~(a0^b0)&br)
  - d shifts into the result register at the MSB end; operand registers shift right; the counter increments.
  - At E_WIDTH (counter = WIDTH−1): if br_next=1, go to NEG; otherwise go to DONE.
- NEG (edges E_WIDTH+1..E_2WIDTH):
  - Serial two's-complement of the raw difference, LSB first.
  - A "seen-one" flag (cleared on entering NEG) controls each bit: bits up to and including the first 1 pass unchanged; later bits are inverted.
  - The raw difference is retained separately for o_diff.
  - After WIDTH edges, go to DONE.
- DONE:
  - On entry, o_diff, o_borrow, o_neg and o_mag are registered.
  - Non-negative result: o_mag = o_diff.
  - o_done=1 for exactly one cycle, then IDLE on the next edge.
- Latency:
  - o_done is high in the cycle after edge E_WIDTH for non-negative results.
  - o_done is high in the cycle after edge E_2WIDTH for negative results.
  - Throughput: one operation per WIDTH+2 or 2·WIDTH+2 cycles, counting the IDLE accept cycle.
- Output hold: results hold their values until the next DONE entry or reset. They are not cleared by a new i_start.
- i_start while o_busy=1 (SUB, NEG, DONE) is ignored. No queuing; the operands of the running operation are unaffected.
- i_a/i_b changing after the capture edge has no effect.
- Width rules:
  - The counter is clog2(WIDTH) bits and must not wrap early.
  - |A − B| ≤ 2^WIDTH − 1 always fits in WIDTH bits, so no overflow flag exists.
- A = B gives o_diff=0, o_borrow=0 and the DONE path with no NEG pass.

Test Plan:
- WIDTH=4, A=9, B=3, start pulse → o_done 4 cycles after the accept edge; o_diff=6, o_borrow=0, o_neg=0, o_mag=6; o_busy high for 5 cycles.
- A=3, B=9 → o_done after 8 processing edges; o_diff=4'b1010 (10), o_borrow=1, o_neg=1, o_mag=6.
- A=0, B=15 → o_diff=1, o_neg=1, o_mag=15; then A=7, B=7 → o_diff=0, o_borrow=0, o_mag=0, no NEG pass.
- Start A=12, B=5; pulse i_start again with A=1, B=2 during SUB → first result only (o_diff=7, o_mag=7); no second o_done; o_busy waveform unchanged.
- Start A=2, B=11; assert i_reset_n=0 mid-NEG → all outputs 0 immediately (asynchronously), no o_done; after release, A=5, B=5 completes normally with all results 0.
- Back-to-back: start on the first IDLE cycle after each o_done for pairs (15,0), (0,1), (8,8) → results (15,0,0,15), (15,1,1,1), (0,0,0,0), each with exactly one o_done pulse.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, with a
// second serial pass that forms |A - B| when the result is negative.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_neg,
  output logic [WIDTH-1:0] o_mag
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   diff_raw;
  logic [CNT_W-1:0]   cnt;
  logic               br;
  logic               seen_one;

  logic               a0;
  logic               b0;
  logic               d;
  logic               br_next;
  logic               neg_bit;
  logic               last;
  logic [WIDTH-1:0]   sub_word;
  logic [WIDTH-1:0]   neg_word;

  // Full-subtractor cell and the serial two's-complement bit.
  always_comb begin
    a0       = a_sh[0];
    b0       = b_sh[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    neg_bit  = seen_one ? ~res_sh[0] : res_sh[0];
    last     = (cnt == CNT_W'(WIDTH - 1));
    sub_word = {d, res_sh[WIDTH-1:1]};
    neg_word = {neg_bit, res_sh[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_start) state_next = SUB;
      SUB:  if (last) state_next = br_next ? NEG : DONE;
      NEG:  if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags track the state being entered so they are registered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_busy <= (state_next != IDLE);
      o_done <= (state_next == DONE);
    end
  end

  // Serial datapath and result registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      diff_raw <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      seen_one <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_neg    <= 1'b0;
      o_mag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sh <= i_a;
            b_sh <= i_b;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SUB: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= sub_word;
          br     <= br_next;
          if (last) begin
            cnt      <= '0;
            seen_one <= 1'b0;
            diff_raw <= sub_word;
            if (!br_next) begin
              o_diff   <= sub_word;
              o_borrow <= 1'b0;
              o_neg    <= 1'b0;
              o_mag    <= sub_word;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEG: begin
          // Bits up to the first 1 pass through, later bits are inverted.
          res_sh   <= neg_word;
          seen_one <= seen_one | res_sh[0];
          if (last) begin
            cnt      <= '0;
            o_diff   <= diff_raw;
            o_borrow <= 1'b1;
            o_neg    <= 1'b1;
            o_mag    <= neg_word;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at start
// and compared when o_done fires; latency, busy and reset behaviour are checked inline.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         neg;
    logic [W-1:0] mag;
  } res_t;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_neg;
  logic [W-1:0] o_mag;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  res_t sb[$];
  res_t last_res = '0;
  res_t mon_e;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_start  (i_start),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_diff   (o_diff),
    .o_borrow (o_borrow),
    .o_neg    (o_neg),
    .o_mag    (o_mag)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    r.diff   = W'(ia - ib + (1 << W));
    r.borrow = (ia < ib);
    r.neg    = (ia < ib);
    r.mag    = (ia < ib) ? W'(ib - ia) : W'(ia - ib);
    return r;
  endfunction

  // Pop and compare on every o_done pulse.
  always @(negedge i_clk) begin
    if (i_reset_n && o_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("diff",   32'(o_diff),   32'(mon_e.diff));
        check("borrow", 32'(o_borrow), 32'(mon_e.borrow));
        check("neg",    32'(o_neg),    32'(mon_e.neg));
        check("mag",    32'(o_mag),    32'(mon_e.mag));
      end
    end
  end

  // Starts an operation in the current IDLE cycle and follows it to IDLE again.
  // inj >= 0 pulses a stray i_start with other operands after that many edges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    res_t e;
    int   n;
    int   busy_n;
    bit   seen;
    e = model(a, b);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_a = W'($urandom);
    i_b = W'($urandom);
    sb.push_back(e);
    check("busy_after_accept", 32'(o_busy), 32'd1);
    check("hold_diff", 32'(o_diff), 32'(last_res.diff));
    check("hold_mag",  32'(o_mag),  32'(last_res.mag));
    n = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && n < 4 * W + 8) begin
      if (n == inj) begin
        i_start = 1'b1;
        i_a = 1;
        i_b = 2;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      n++;
      if (o_busy) busy_n++;
      if (o_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), e.neg ? 32'(2 * W) : 32'(W));
    check("busy_cycles", 32'(busy_n), 32'(n));
    @(posedge i_clk); #1;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_after_done", 32'(o_busy), 32'd0);
    last_res = e;
  endtask

  initial begin
    int base;
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_a       = '0;
    i_b       = '0;
    #12;
    check("reset_outputs", 32'({o_busy, o_done, o_diff, o_borrow, o_neg, o_mag}), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    run_op(4'd9, 4'd3, -1);
    run_op(4'd3, 4'd9, -1);
    run_op(4'd0, 4'd15, -1);
    run_op(4'd7, 4'd7, -1);

    // Stray start during SUB must be ignored.
    base = done_cnt;
    run_op(4'd12, 4'd5, 1);
    repeat (2 * W + 4) @(posedge i_clk);
    #1;
    check("no_second_done", 32'(done_cnt - base), 32'd1);
    check("idle_after_stray", 32'(o_busy), 32'd0);
    check("stray_hold_diff", 32'(o_diff), 32'd7);

    // Asynchronous reset in the middle of the NEG pass.
    base = done_cnt;
    i_a = 4'd2;
    i_b = 4'd11;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    check("busy_mid_neg", 32'(o_busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({o_busy, o_done, o_diff, o_borrow, o_neg, o_mag}), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3 * W) @(posedge i_clk);
    #1;
    check("no_done_after_reset", 32'(done_cnt - base), 32'd0);
    check("idle_after_reset", 32'(o_busy), 32'd0);
    last_res = '0;

    run_op(4'd5, 4'd5, -1);

    // Back-to-back operations.
    run_op(4'd15, 4'd0, -1);
    run_op(4'd0, 4'd1, -1);
    run_op(4'd8, 4'd8, -1);

    for (int k = 0; k < 8; k++) begin
      run_op(W'($urandom), W'($urandom), -1);
    end

    repeat (4) @(posedge i_clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("total_done", 32'(done_cnt), 32'd17);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
